// File: rtl/program_loader.sv
// program_loader: assembles framed stream bytes into program words and writes them while holding the CPU
module program_loader #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PC_WIDTH = 8,
  parameter logic [7:0] START_BYTE = 8'hA5
) (
  input  logic clock,
  input  logic isReset,
  input  logic byteValid,
  input  logic [7:0] byteData,
  output logic byteReady,
  output logic memWriteEnable,
  output logic [PC_WIDTH-1:0] memWriteAddress,
  output logic [INSTRUCTION_WIDTH-1:0] memWriteData,
  output logic cpuHold,
  output logic loadDone,
  output logic loadError
);
  localparam int BPW = INSTRUCTION_WIDTH / 8;
  localparam int BW = $clog2(BPW) + 1;
  localparam int CW = PC_WIDTH + 1;
  localparam int DEPTH = 2 ** PC_WIDTH;
  typedef enum logic [2:0] {IDLE, LENGTH, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] byte_cnt_q;
  logic [CW-1:0] word_cnt_q, len_q;
  logic [INSTRUCTION_WIDTH-1:0] word_q;
  logic [7:0] sum_q;
  logic hold_q, err_q;
  logic xfer, is_start, last_byte, last_word, bad_len;
  assign byteReady = !(state_q == WRITE || state_q == DONE || state_q == ERROR);
  assign xfer = byteValid && byteReady;
  assign is_start = byteData == START_BYTE;
  assign last_byte = byte_cnt_q == BW'(BPW - 1);
  assign last_word = word_cnt_q + CW'(1) == len_q;
  assign bad_len = byteData == 8'd0 || int'(byteData) > DEPTH;
  assign memWriteEnable = state_q == WRITE;
  assign memWriteAddress = word_cnt_q[PC_WIDTH-1:0];
  assign memWriteData = word_q;
  assign cpuHold = hold_q;
  assign loadDone = state_q == DONE;
  assign loadError = err_q;
  // state register; reset abandons any partial frame
  always_ff @(posedge clock) begin
    if (isReset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // frame sequencing: each word write takes its own cycle before the next byte is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && is_start) state_d = LENGTH;
      LENGTH:  if (xfer) state_d = bad_len ? ERROR : DATA;
      DATA:    if (xfer && last_byte) state_d = WRITE;
      WRITE:   state_d = last_word ? CHECK : DATA;
      CHECK:   if (xfer) state_d = byteData == sum_q ? DONE : ERROR;
      default: state_d = IDLE;
    endcase
  end
  // word assembly, counters, checksum and the sticky hold/error flags
  always_ff @(posedge clock) begin
    if (isReset) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q <= '0;
      word_q <= '0;
      sum_q <= '0;
      hold_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && xfer && is_start) begin
        hold_q <= 1'b1;
        err_q <= 1'b0;
      end
      if (state_q == LENGTH && xfer) begin
        len_q <= CW'(byteData);
        byte_cnt_q <= '0;
        word_cnt_q <= '0;
        sum_q <= '0;
      end
      if (state_q == DATA && xfer) begin
        word_q <= INSTRUCTION_WIDTH'({word_q, byteData});
        sum_q <= sum_q + byteData;
        byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BW'(1);
      end
      if (state_q == WRITE) word_cnt_q <= word_cnt_q + CW'(1);
      if (state_q == DONE) hold_q <= 1'b0;
      if (state_q == ERROR) err_q <= 1'b1;
    end
  end
endmodule
